// File: rtl/dtack_wait_state_generator.sv
// rtl/dtack_wait_state_generator.sv - 68k DTACK wait-state generator with bus-error timeout
module dtack_wait_state_generator #(
    parameter int ROM_WAIT = 1,
    parameter int RAM_WAIT = 1,
    parameter int IO_WAIT  = 2,
    parameter int GFX_WAIT = 3,
    parameter int TIMEOUT  = 255,
    parameter int CNT_W    = 8
) (
    input  logic Clk,
    input  logic Reset_H,
    input  logic AS_L,
    input  logic UDS_L,
    input  logic LDS_L,
    input  logic OnChipRomSelect_H,
    input  logic OnChipRamSelect_H,
    input  logic DramSelect_H,
    input  logic IOSelect_H,
    input  logic GraphicsCS_L,
    input  logic VoiceControl_H,
    input  logic wrencursor,
    input  logic CanBusSelect_H,
    input  logic DramDtack_L,
    input  logic CanBusDtack_L,
    output logic DtAck_L,
    output logic BusError_L,
    output logic Busy_H
);

    typedef enum logic [2:0] {IDLE, COUNT, EXTWAIT, ACK, BERR} state_t;

    localparam logic [CNT_W-1:0] ROM_C     = CNT_W'(ROM_WAIT);
    localparam logic [CNT_W-1:0] RAM_C     = CNT_W'(RAM_WAIT);
    localparam logic [CNT_W-1:0] IO_C      = CNT_W'(IO_WAIT);
    localparam logic [CNT_W-1:0] GFX_C     = CNT_W'(GFX_WAIT);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

    state_t           state, nextState;
    logic [CNT_W-1:0] waitCnt, waitCntNext;
    logic [CNT_W-1:0] toCnt, toCntNext, toCntInc;
    logic             extIsCan, extIsCanNext;
    logic             extAckSeen, extAckSeenNext;
    logic             startCycle, gfxSelect, extDtackLow, timeoutHit;
    logic             timedSel, extSel, canSel;
    logic [CNT_W-1:0] selWait;

    assign startCycle  = ~AS_L & (~UDS_L | ~LDS_L);
    assign gfxSelect   = GraphicsCS_L | VoiceControl_H | wrencursor;
    assign extDtackLow = extIsCan ? ~CanBusDtack_L : ~DramDtack_L;
    assign toCntInc    = (&toCnt) ? toCnt : toCnt + ONE_C;
    assign timeoutHit  = (toCntInc >= TIMEOUT_C);

    // Device priority encoder; a zero selWait with timedSel low means "unclaimed"
    always_comb begin
        selWait  = '0;
        timedSel = 1'b1;
        extSel   = 1'b0;
        canSel   = 1'b0;
        if (OnChipRomSelect_H)      selWait = ROM_C;
        else if (OnChipRamSelect_H) selWait = RAM_C;
        else if (DramSelect_H) begin
            timedSel = 1'b0;
            extSel   = 1'b1;
        end
        else if (IOSelect_H)        selWait = IO_C;
        else if (gfxSelect)         selWait = GFX_C;
        else if (CanBusSelect_H) begin
            timedSel = 1'b0;
            extSel   = 1'b1;
            canSel   = 1'b1;
        end
        else                        timedSel = 1'b0;
    end

    always_comb begin
        nextState      = state;
        waitCntNext    = waitCnt;
        toCntNext      = toCnt;
        extIsCanNext   = extIsCan;
        extAckSeenNext = extAckSeen;
        case (state)
            IDLE: begin
                if (startCycle) begin
                    toCntNext      = '0;
                    waitCntNext    = selWait;
                    extIsCanNext   = canSel;
                    extAckSeenNext = 1'b0;
                    if (extSel)                        nextState = EXTWAIT;
                    else if (timedSel && selWait == '0) nextState = ACK;
                    else                               nextState = COUNT;
                end
            end
            // waitCnt of zero here means an unclaimed cycle: only the timeout ends it
            COUNT: begin
                if (AS_L)                 nextState = IDLE;
                else if (waitCnt == ONE_C) nextState = ACK;
                else if (timeoutHit)      nextState = BERR;
                else begin
                    if (waitCnt > ONE_C) waitCntNext = waitCnt - ONE_C;
                    toCntNext = toCntInc;
                end
            end
            // A sampled device ack is registered for one edge and then beats the timeout
            EXTWAIT: begin
                if (AS_L)            nextState = IDLE;
                else if (extAckSeen) nextState = ACK;
                else if (extDtackLow) begin
                    extAckSeenNext = 1'b1;
                    toCntNext      = toCntInc;
                end
                else if (timeoutHit) nextState = BERR;
                else                 toCntNext = toCntInc;
            end
            ACK, BERR: begin
                if (AS_L) nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset_H) begin
            state      <= IDLE;
            waitCnt    <= '0;
            toCnt      <= '0;
            extIsCan   <= 1'b0;
            extAckSeen <= 1'b0;
            DtAck_L    <= 1'b1;
            BusError_L <= 1'b1;
            Busy_H     <= 1'b0;
        end else begin
            state      <= nextState;
            waitCnt    <= waitCntNext;
            toCnt      <= toCntNext;
            extIsCan   <= extIsCanNext;
            extAckSeen <= extAckSeenNext;
            DtAck_L    <= (nextState != ACK);
            BusError_L <= (nextState != BERR);
            Busy_H     <= (nextState != IDLE);
        end
    end

endmodule

// File: tb/tb_dtack_wait_state_generator.sv
// tb/tb_dtack_wait_state_generator.sv - self-checking bench for dtack_wait_state_generator
module tb_dtack_wait_state_generator;

    localparam int ROM_W = 1;
    localparam int RAM_W = 1;
    localparam int IO_W  = 2;
    localparam int GFX_W = 3;
    localparam int TMO   = 255;

    logic Clk, Reset_H, AS_L, UDS_L, LDS_L;
    logic OnChipRomSelect_H, OnChipRamSelect_H, DramSelect_H, IOSelect_H;
    logic GraphicsCS_L, VoiceControl_H, wrencursor, CanBusSelect_H;
    logic DramDtack_L, CanBusDtack_L;
    logic DtAck_L, BusError_L, Busy_H;

    int nCompared = 0;
    int nFailed   = 0;
    bit checkEn   = 0;

    // Reference model: cycle bookkeeping by edge number
    int edgeN  = 0;
    int mBusy  = 0;
    int mTerm  = 0;   // 0 waiting, 1 acknowledged, 2 bus error
    int mKind  = 0;   // 0 timed, 1 unclaimed, 2 DRAM, 3 CAN
    int mE0    = 0;
    int mN     = 0;
    int mClaim = 0;

    dtack_wait_state_generator #(
        .ROM_WAIT(ROM_W), .RAM_WAIT(RAM_W), .IO_WAIT(IO_W), .GFX_WAIT(GFX_W),
        .TIMEOUT(TMO), .CNT_W(8)
    ) dut (
        .Clk(Clk), .Reset_H(Reset_H), .AS_L(AS_L), .UDS_L(UDS_L), .LDS_L(LDS_L),
        .OnChipRomSelect_H(OnChipRomSelect_H), .OnChipRamSelect_H(OnChipRamSelect_H),
        .DramSelect_H(DramSelect_H), .IOSelect_H(IOSelect_H), .GraphicsCS_L(GraphicsCS_L),
        .VoiceControl_H(VoiceControl_H), .wrencursor(wrencursor), .CanBusSelect_H(CanBusSelect_H),
        .DramDtack_L(DramDtack_L), .CanBusDtack_L(CanBusDtack_L),
        .DtAck_L(DtAck_L), .BusError_L(BusError_L), .Busy_H(Busy_H)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nFailed++;
            $display("FAIL %s: got %0d expected %0d at edge %0d", name, act, exp, edgeN);
        end
    endtask

    task automatic modelStep();
        int t;
        edgeN++;
        t = edgeN - mE0;
        if (Reset_H) begin
            mBusy = 0;
            mTerm = 0;
        end else if (mBusy == 0) begin
            if (!AS_L && (!UDS_L || !LDS_L)) begin
                mBusy = 1; mTerm = 0; mE0 = edgeN; mClaim = 0;
                if (OnChipRomSelect_H)      begin mKind = 0; mN = ROM_W; end
                else if (OnChipRamSelect_H) begin mKind = 0; mN = RAM_W; end
                else if (DramSelect_H)      mKind = 2;
                else if (IOSelect_H)        begin mKind = 0; mN = IO_W; end
                else if (GraphicsCS_L || VoiceControl_H || wrencursor) begin mKind = 0; mN = GFX_W; end
                else if (CanBusSelect_H)    mKind = 3;
                else                        mKind = 1;
                if (mKind == 0 && mN == 0) mTerm = 1;
            end
        end else if (mTerm != 0) begin
            if (AS_L) begin mBusy = 0; mTerm = 0; end
        end else begin
            if (AS_L)                             mBusy = 0;
            else if (mKind == 0 && t == mN)       mTerm = 1;
            else if (mKind >= 2 && mClaim != 0)   mTerm = 1;
            else if (mKind >= 2 && ((mKind == 2) ? DramDtack_L : CanBusDtack_L) == 1'b0) mClaim = 1;
            else if (t >= TMO)                    mTerm = 2;
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        modelStep();
        #1;
    endtask

    always @(negedge Clk) begin
        if (checkEn) begin
            check("model_dtack", {31'd0, DtAck_L}, (mBusy != 0 && mTerm == 1) ? 0 : 1);
            check("model_berr",  {31'd0, BusError_L}, (mBusy != 0 && mTerm == 2) ? 0 : 1);
            check("model_busy",  {31'd0, Busy_H}, (mBusy != 0) ? 1 : 0);
            check("exclusive",   {31'd0, DtAck_L | BusError_L}, 1);
        end
    end

    // sel bits: 0 rom, 1 ram, 2 dram, 3 io, 4 gfx, 5 voice, 6 cursor, 7 can
    task automatic setSel(input logic [7:0] sel);
        OnChipRomSelect_H = sel[0];
        OnChipRamSelect_H = sel[1];
        DramSelect_H      = sel[2];
        IOSelect_H        = sel[3];
        GraphicsCS_L      = sel[4];
        VoiceControl_H    = sel[5];
        wrencursor        = sel[6];
        CanBusSelect_H    = sel[7];
    endtask

    task automatic idleInputs();
        AS_L = 1; UDS_L = 1; LDS_L = 1; DramDtack_L = 1; CanBusDtack_L = 1;
        setSel(8'h00);
    endtask

    // Runs one cycle; returns edge offsets from E0 of the first DtAck_L/BusError_L low (-1 if none)
    task automatic measure(input logic [7:0] sel, input int dramAt, input int limit,
                           output int ackAt, output int berrAt);
        ackAt = -1; berrAt = -1;
        setSel(sel);
        AS_L = 0; UDS_L = 0; LDS_L = 1; DramDtack_L = 1; CanBusDtack_L = 1;
        tick();
        for (int k = 1; k <= limit && ackAt < 0 && berrAt < 0; k++) begin
            DramDtack_L   = (dramAt >= 0 && k >= dramAt) ? 1'b0 : 1'b1;
            CanBusDtack_L = 1'($urandom_range(0, 1));
            UDS_L         = 1'($urandom_range(0, 1));
            tick();
            if (!DtAck_L)    ackAt = k;
            if (!BusError_L) berrAt = k;
        end
        for (int h = 0; h < 3; h++) tick();
        idleInputs();
        tick();
        check("release_dtack", {31'd0, DtAck_L}, 1);
        check("release_berr",  {31'd0, BusError_L}, 1);
        check("release_busy",  {31'd0, Busy_H}, 0);
        tick();
    endtask

    initial begin
        int ackAt, berrAt, hold;
        idleInputs();
        Reset_H = 1;
        tick();
        checkEn = 1;
        tick();
        check("reset_dtack", {31'd0, DtAck_L}, 1);
        check("reset_berr",  {31'd0, BusError_L}, 1);
        check("reset_busy",  {31'd0, Busy_H}, 0);
        Reset_H = 0;
        tick();

        measure(8'h01, -1, 20, ackAt, berrAt);  check("rom_ack", ackAt, 1);
        measure(8'h10, -1, 20, ackAt, berrAt);  check("gfx_ack", ackAt, 3);
        measure(8'h40, -1, 20, ackAt, berrAt);  check("cursor_ack", ackAt, 3);
        measure(8'h20, -1, 20, ackAt, berrAt);  check("voice_ack", ackAt, 3);
        measure(8'h08, -1, 20, ackAt, berrAt);  check("io_ack", ackAt, 2);
        measure(8'h09, -1, 20, ackAt, berrAt);  check("rom_io_priority", ackAt, 1);
        measure(8'h04, 5, 20, ackAt, berrAt);   check("dram_ack", ackAt, 6);
        measure(8'h00, -1, 300, ackAt, berrAt);
        check("unmapped_berr", berrAt, 255);
        check("unmapped_noack", ackAt, -1);
        measure(8'h04, 255, 300, ackAt, berrAt);
        check("dram_tmo_ack", ackAt, 256);
        check("dram_tmo_noberr", berrAt, -1);

        // Abort of an IO cycle one edge after start
        setSel(8'h08); AS_L = 0; LDS_L = 0;
        tick();
        AS_L = 1;
        tick();
        check("abort_busy", {31'd0, Busy_H}, 0);
        tick();
        check("abort_dtack", {31'd0, DtAck_L}, 1);
        idleInputs();
        tick();

        // Reset while acknowledging
        setSel(8'h01); AS_L = 0; UDS_L = 0;
        tick(); tick();
        check("pre_reset_ack", {31'd0, DtAck_L}, 0);
        Reset_H = 1;
        tick();
        check("reset_ack_dtack", {31'd0, DtAck_L}, 1);
        check("reset_ack_busy",  {31'd0, Busy_H}, 0);
        Reset_H = 0;
        idleInputs();
        tick();

        // Back-to-back: restart on the edge after the return to IDLE
        setSel(8'h01); AS_L = 0; UDS_L = 0;
        tick(); tick();
        AS_L = 1;
        tick();
        check("b2b_idle", {31'd0, Busy_H}, 0);
        AS_L = 0;
        tick();
        check("b2b_restart", {31'd0, Busy_H}, 1);
        tick();
        check("b2b_ack", {31'd0, DtAck_L}, 0);
        idleInputs();
        tick();

        // Randomized traffic
        hold = 0;
        for (int c = 0; c < 9000; c++) begin
            Reset_H = ($urandom_range(0, 499) == 0);
            if (hold > 0) begin
                hold--;
            end else begin
                AS_L = ~AS_L;
                if (!AS_L) begin
                    setSel(8'($urandom) & 8'($urandom));
                    if ($urandom_range(0, 11) == 0) begin
                        hold = 270;
                        if ($urandom_range(0, 1) == 0) setSel(8'h00);
                    end else begin
                        hold = $urandom_range(1, 15);
                    end
                end else begin
                    hold = $urandom_range(0, 3);
                end
            end
            if ($urandom_range(0, 15) == 0) setSel(8'($urandom));
            UDS_L         = ($urandom_range(0, 2) == 0);
            LDS_L         = ($urandom_range(0, 2) == 0);
            DramDtack_L   = ($urandom_range(0, 7) != 0);
            CanBusDtack_L = ($urandom_range(0, 7) != 0);
            tick();
        end
        Reset_H = 0;
        idleInputs();
        tick(); tick();

        checkEn = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
        $finish;
    end

endmodule

// File: doc/dtack_wait_state_generator.md
Name: dtack_wait_state_generator

Overview:
- Bus-cycle acknowledge stage directly downstream of the 68k address decoder.
- Consumes the decoder's per-device select lines plus CPU strobes; produces a registered DtAck_L after a per-device programmable wait count, or forwards acknowledges from self-timed devices (DRAM, CAN).
- Unclaimed or stalled cycles are terminated with BusError_L after a timeout, so the CPU never hangs.

Parameters:
- ROM_WAIT, 1, wait cycles for on-chip ROM.
- RAM_WAIT, 1, wait cycles for on-chip RAM.
- IO_WAIT, 2, wait cycles for IO.
- GFX_WAIT, 3, wait cycles for graphics, voice control and cursor selects.
- TIMEOUT, 255, cycles from cycle start to bus error; must satisfy TIMEOUT > every *_WAIT.
- CNT_W, 8, counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset_H  in  1  synchronous reset, active high.
- AS_L  in  1  CPU address strobe.
- UDS_L  in  1  upper data strobe.
- LDS_L  in  1  lower data strobe.
- OnChipRomSelect_H  in  1  decoder select.
- OnChipRamSelect_H  in  1  decoder select.
- DramSelect_H  in  1  decoder select.
- IOSelect_H  in  1  decoder select.
- GraphicsCS_L  in  1  graphics select; asserted = 1 as driven by the decoder.
- VoiceControl_H  in  1  decoder select.
- wrencursor  in  1  cursor select, active high.
- CanBusSelect_H  in  1  decoder select.
- DramDtack_L  in  1  acknowledge from the DRAM controller.
- CanBusDtack_L  in  1  acknowledge from the CAN interface.
- DtAck_L  out  1  registered data-transfer acknowledge to the CPU.
- BusError_L  out  1  registered bus error to the CPU.
- Busy_H  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset: synchronous on Reset_H. Next edge forces state IDLE, counters 0, DtAck_L=1, BusError_L=1, Busy_H=0. This applies mid-cycle too; the aborted cycle is never acknowledged.
- Start condition: in IDLE, AS_L=0 and (UDS_L=0 or LDS_L=0) sampled at edge E0.
- Device priority when several selects are high: ROM > RAM > DRAM > IO > GFX (graphics/voice/cursor) > CAN > none.
- States:
  - IDLE.
  - COUNT: internally timed devices.
  - EXTWAIT: DRAM/CAN.
  - ACK.
  - BERR.
- IDLE -> COUNT at E0 for ROM, RAM, IO or GFX. Wait counter loads N; if N=0, go straight to ACK.
- COUNT: when wait counter = 1, go to ACK; else decrement. DtAck_L goes low at edge E0+N, exactly N cycles after start.
- IDLE -> EXTWAIT at E0 for DRAM or CAN.
  - EXTWAIT: the selected device's Dtack_L sampled 0 at edge Ek gives DtAck_L=0 at Ek+1 (one-cycle registering).
  - The other device's Dtack_L is ignored.
- IDLE -> BERR path for no select: stay in COUNT with no wait expiry; only the timeout applies.
- Timeout counter: cleared at E0, increments every edge in COUNT or EXTWAIT. Reaching TIMEOUT -> BERR with BusError_L=0, DtAck_L stays 1.
- Simultaneous timeout and ack/expiry on the same edge: ack wins.
- ACK / BERR: hold the output low while AS_L=0. First edge sampling AS_L=1 -> IDLE, output returns to 1 on that edge.
- A new cycle cannot start on the same edge as the return to IDLE. Minimum one IDLE cycle between cycles.
- Abort: AS_L=1 sampled in COUNT or EXTWAIT -> IDLE, no DtAck_L/BusError_L pulse.
- Strobes: UDS_L/LDS_L are checked only at start. Later changes are ignored until AS_L rises.
- Outputs never glitch: both come straight from flops, and DtAck_L and BusError_L are never low simultaneously.
- Counter arithmetic is unsigned CNT_W bits and saturates; no wrap.

Test Plan:
- ROM read: AS_L=0, UDS_L=0, OnChipRomSelect_H=1 at E0 -> DtAck_L=0 at E0+1; hold 3 cycles; AS_L=1 -> DtAck_L=1 on the next edge, Busy_H=0.
- Graphics with GFX_WAIT=3: GraphicsCS_L=1 at E0 -> DtAck_L=1 through E0+2, 0 at E0+3. Repeat with wrencursor and VoiceControl_H.
- DRAM: DramSelect_H=1 at E0, DramDtack_L low at E0+5 -> DtAck_L=0 at E0+6. CanBusDtack_L toggling during the cycle has no effect.
- Unmapped address: no selects, AS_L=0 held -> BusError_L=0 at E0+255, DtAck_L=1; AS_L release -> BusError_L=1. DRAM with DramDtack_L asserted exactly at the timeout edge -> DtAck_L wins.
- Priority: ROM and IO selected together -> acknowledge at E0+1 (ROM timing, not IO's E0+2).
- Abort/reset: IO cycle with AS_L=1 at E0+1 -> no DtAck_L pulse. Reset_H=1 during ACK -> DtAck_L=1 and Busy_H=0 the next edge. Back-to-back cycles honour one IDLE cycle.
